// File: rtl/bn_pkg.sv
// bn_pkg: shared constants, widths and FSM encoding for the secp256k1 big-number reduction slice.
package bn_pkg;

  localparam int WORD_W  = 32;
  localparam int N_WORDS = 8;
  localparam int FIELD_W = WORD_W * N_WORDS;
  localparam int PROD_W  = 2 * FIELD_W;
  localparam int CARRY_W = 12;
  localparam int ACC_W   = 46;
  localparam int T8_W    = 34;
  localparam int PC_W    = 10;

  localparam int P_C_DEFAULT = 977;

  localparam logic [3:0] FOLD1_LAST = 4'(N_WORDS);
  localparam logic [3:0] WORD_LAST  = 4'(N_WORDS - 1);

  localparam logic [FIELD_W-1:0] SECP256K1_P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FOLD1 = 3'd1,
    ST_FOLD2 = 3'd2,
    ST_SUB   = 3'd3,
    ST_SEL   = 3'd4,
    ST_DONE  = 3'd5
  } bn_state_e;

endpackage

// File: rtl/bn_word_mac.sv
// bn_word_mac: one word step a + b*P_C + c + carry_in, split into a 32-bit word and a 12-bit carry.
module bn_word_mac
  import bn_pkg::*;
#(
  parameter int P_C = P_C_DEFAULT
) (
  input  logic [WORD_W-1:0]  a,
  input  logic [T8_W-1:0]    b,
  input  logic [T8_W-1:0]    c,
  input  logic [CARRY_W-1:0] carry_in,
  output logic [WORD_W-1:0]  word_out,
  output logic [CARRY_W-1:0] carry_out
);

  localparam logic [PC_W-1:0] PC = PC_W'(P_C);

  logic [ACC_W-1:0] acc;
  logic             unused_acc_hi;

  assign acc = ACC_W'(a) + ACC_W'(b) * ACC_W'(PC) + ACC_W'(c) + ACC_W'(carry_in);

  assign word_out  = acc[WORD_W-1:0];
  assign carry_out = acc[WORD_W +: CARRY_W];
  // The top two bits stay zero for every legal operand range.
  assign unused_acc_hi = ^acc[ACC_W-1:WORD_W+CARRY_W];

endmodule

// File: rtl/bn_reduce.sv
// bn_reduce: serial reduction of a 512-bit product modulo p = 2^256 - 2^32 - P_C, one word per cycle.
// Define BN_REDUCE_CANONICAL_EN to force the result into [0, p); otherwise it is only < 2^256.
module bn_reduce
  import bn_pkg::*;
#(
  parameter int P_C = P_C_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PROD_W-1:0]  rx_a,
  output logic               tx_done,
  output logic [FIELD_W-1:0] tx_r
);

  localparam logic [FIELD_W-1:0] P_MOD =
    SECP256K1_P + FIELD_W'(P_C_DEFAULT) - FIELD_W'(P_C);

  bn_state_e          state_reg, state_next;
  logic [3:0]         word_reg, word_next;
  logic [2:0]         k, k_prev;

  logic [WORD_W-1:0]  l_words [N_WORDS];
  logic [WORD_W-1:0]  h_words [N_WORDS];
  logic [WORD_W-1:0]  p_words [N_WORDS];
  logic [WORD_W-1:0]  u_reg   [N_WORDS];
  logic [WORD_W-1:0]  d_reg   [N_WORDS];
  logic [FIELD_W-1:0] u_flat, d_flat;

  logic [T8_W-1:0]    t8_reg;
  logic [CARRY_W-1:0] carry_reg;
  logic               u256_reg, borrow_reg, select;

  logic [WORD_W-1:0]  mac_a, mac_word;
  logic [T8_W-1:0]    mac_b, mac_c;
  logic [CARRY_W-1:0] mac_cin, mac_carry;
  logic [WORD_W:0]    diff;

  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
    assign l_words[gi] = rx_a[WORD_W*gi +: WORD_W];
    assign h_words[gi] = rx_a[FIELD_W + WORD_W*gi +: WORD_W];
    assign p_words[gi] = P_MOD[WORD_W*gi +: WORD_W];
    assign u_flat[WORD_W*gi +: WORD_W] = u_reg[gi];
    assign d_flat[WORD_W*gi +: WORD_W] = d_reg[gi];
  end

  assign k      = word_reg[2:0];
  assign k_prev = k - 3'd1;

`ifdef BN_REDUCE_CANONICAL_EN
  assign select = u256_reg | ~borrow_reg;
`else
  assign select = u256_reg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      word_reg  <= 4'd0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
    end
  end

  // IDLE is the held-in-reset state; its single edge already folds word 0.
  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_FOLD1;
        word_next  = 4'd1;
      end
      ST_FOLD1: begin
        if (word_reg == FOLD1_LAST) begin
          state_next = ST_FOLD2;
          word_next  = 4'd0;
        end else begin
          word_next = word_reg + 4'd1;
        end
      end
      ST_FOLD2: begin
        if (word_reg == WORD_LAST) begin
          state_next = ST_SUB;
          word_next  = 4'd0;
        end else begin
          word_next = word_reg + 4'd1;
        end
      end
      ST_SUB: begin
        if (word_reg == WORD_LAST) begin
          state_next = ST_SEL;
          word_next  = 4'd0;
        end else begin
          word_next = word_reg + 4'd1;
        end
      end
      ST_SEL:  state_next = ST_DONE;
      ST_DONE: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    mac_a   = '0;
    mac_b   = '0;
    mac_c   = '0;
    mac_cin = carry_reg;
    case (state_reg)
      ST_IDLE, ST_FOLD1: begin
        // Word 8 only collects the shifted-in H7 plus the running carry.
        if (word_reg != FOLD1_LAST) begin
          mac_a = l_words[k];
          mac_b = T8_W'(h_words[k]);
        end
        if (word_reg != 4'd0) mac_c = T8_W'(h_words[k_prev]);
      end
      ST_FOLD2: begin
        mac_a = u_reg[k];
        if (word_reg == 4'd0) mac_b = t8_reg;
        if (word_reg == 4'd1) mac_c = t8_reg;
      end
      default: mac_cin = '0;
    endcase
  end

  bn_word_mac #(.P_C(P_C)) u_mac (
    .a         (mac_a),
    .b         (mac_b),
    .c         (mac_c),
    .carry_in  (mac_cin),
    .word_out  (mac_word),
    .carry_out (mac_carry)
  );

  assign diff = {1'b0, u_reg[k]} - {1'b0, p_words[k]} - {{WORD_W{1'b0}}, borrow_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_WORDS; i++) begin
        u_reg[i] <= '0;
        d_reg[i] <= '0;
      end
      t8_reg     <= '0;
      carry_reg  <= '0;
      u256_reg   <= 1'b0;
      borrow_reg <= 1'b0;
      tx_done    <= 1'b0;
      tx_r       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_FOLD1: begin
          if (word_reg == FOLD1_LAST) begin
            t8_reg    <= {mac_carry[1:0], mac_word};
            carry_reg <= '0;
          end else begin
            u_reg[k]  <= mac_word;
            carry_reg <= mac_carry;
          end
        end
        ST_FOLD2: begin
          u_reg[k]  <= mac_word;
          carry_reg <= mac_carry;
          if (word_reg == WORD_LAST) u256_reg <= mac_carry[0];
        end
        ST_SUB: begin
          d_reg[k]   <= diff[WORD_W-1:0];
          borrow_reg <= diff[WORD_W];
        end
        ST_SEL: begin
          tx_r    <= select ? d_flat : u_flat;
          tx_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bn_reduce.sv
// tb_bn_reduce: directed and random reductions checked against a wide-integer model of the modular fold.
module tb_bn_reduce;
  import bn_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [PROD_W-1:0]  rx_a = '0;
  logic               tx_done;
  logic [FIELD_W-1:0] tx_r;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [599:0] PM = 600'(SECP256K1_P);
  localparam logic [599:0] CC = 600'(33'h1_0000_0000) + 600'(P_C_DEFAULT);

  bn_reduce dut (
    .clk     (clk),
    .reset   (reset),
    .rx_a    (rx_a),
    .tx_done (tx_done),
    .tx_r    (tx_r)
  );

  always #5 clk = ~clk;

  // Two folds with 2^256 == 2^32 + P_C, then one conditional subtraction of p.
  function automatic logic [FIELD_W-1:0] ref_reduce(input logic [PROD_W-1:0] x);
    logic [599:0] t, u;
    t = 600'(x[FIELD_W-1:0]) + 600'(x[PROD_W-1:FIELD_W]) * CC;
    u = 600'(t[FIELD_W-1:0]) + 600'(t[599:FIELD_W]) * CC;
`ifdef BN_REDUCE_CANONICAL_EN
    return FIELD_W'(600'(x) % PM);
`else
    return (u >= (600'd1 << FIELD_W)) ? FIELD_W'(u - PM) : FIELD_W'(u);
`endif
  endfunction

  task automatic check(input string tag, input logic [FIELD_W-1:0] obs, input logic [FIELD_W-1:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Assumes reset is high; loads x, releases reset and walks the 26 edges.
  task automatic run_from_release(input string tag, input logic [PROD_W-1:0] x, input logic [FIELD_W-1:0] exp);
    rx_a = x;
    @(negedge clk);
    reset = 1'b0;
    for (int n = 1; n <= 26; n++) begin
      @(posedge clk);
      #1;
      if (n < 26) begin
        check({tag, "/busy_done"}, FIELD_W'(tx_done), '0);
        check({tag, "/busy_r"}, tx_r, '0);
      end
    end
    check({tag, "/done"}, FIELD_W'(tx_done), FIELD_W'(1));
    check({tag, "/r"}, tx_r, exp);
    check({tag, "/congruent"}, FIELD_W'(600'(tx_r) % PM), FIELD_W'(600'(x) % PM));
    $display("case %s rx_a=%h tx_r=%h", tag, x, tx_r);
    rx_a = ~x;
    repeat (2) @(posedge clk);
    #1;
    check({tag, "/hold_r"}, tx_r, exp);
    check({tag, "/hold_done"}, FIELD_W'(tx_done), FIELD_W'(1));
  endtask

  task automatic run_case(input string tag, input logic [PROD_W-1:0] x, input logic [FIELD_W-1:0] exp);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check({tag, "/rst_done"}, FIELD_W'(tx_done), '0);
    check({tag, "/rst_r"}, tx_r, '0);
    run_from_release(tag, x, exp);
  endtask

  initial begin
    logic [PROD_W-1:0]  x;
    logic [FIELD_W-1:0] exp;
    logic [FIELD_W-1:0] pm1;

    run_case("zero", '0, '0);

`ifdef BN_REDUCE_CANONICAL_EN
    exp = '0;
`else
    exp = SECP256K1_P;
`endif
    run_case("p", PROD_W'(SECP256K1_P), exp);

    x = PROD_W'(1) << FIELD_W;
    run_case("two256", x, 256'h1_0000_03D1);

    pm1 = SECP256K1_P - 256'd1;
    x = PROD_W'(pm1) * PROD_W'(pm1);
`ifdef BN_REDUCE_CANONICAL_EN
    exp = 256'd1;
`else
    exp = ref_reduce(x);
`endif
    run_case("pm1_sq", x, exp);

    x = '1;
    run_case("all_ones", x, 256'h1_0000_07A2_000E_90A0);

    // Asynchronous clear straight out of DONE, with no clock edge in between.
    #2;
    reset = 1'b1;
    #1;
    check("async_clr_done", FIELD_W'(tx_done), '0);
    check("async_clr_r", tx_r, '0);

    // Abort mid-reduction, then restart on a new operand.
    @(negedge clk);
    rx_a = PROD_W'(1) << FIELD_W;
    reset = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      check("abort_busy_done", FIELD_W'(tx_done), '0);
    end
    #1;
    reset = 1'b1;
    #1;
    check("abort_done", FIELD_W'(tx_done), '0);
    check("abort_r", tx_r, '0);
    x = PROD_W'(SECP256K1_P + 256'd5);
`ifdef BN_REDUCE_CANONICAL_EN
    exp = 256'd5;
`else
    exp = SECP256K1_P + 256'd5;
`endif
    run_from_release("restart_p5", x, exp);

    for (int i = 0; i < 24; i++) begin
      for (int w = 0; w < 16; w++) x[32*w +: 32] = $urandom;
      if (i % 4 == 0) x[PROD_W-1:288] = '1;
      if (i % 4 == 1) x = PROD_W'(SECP256K1_P + FIELD_W'($urandom_range(0, 1000)));
      if (i % 4 == 2) x[FIELD_W-1:0] = '1;
      run_case($sformatf("rand%0d", i), x, ref_reduce(x));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
